dsp_mac_sequencer: RTL and testbench

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_mac_sequencer.sv | 163 ++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Sequences a stream of 18x18 operand pairs through an external multiply-accumulate
// DSP slice and returns the 48-bit accumulated dot product over a valid/ready port.
module dsp_mac_sequencer #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [47:0]      res_data,
    output logic [17:0]      dsp_A,
    output logic [17:0]      dsp_B,
    output logic [7:0]       dsp_OPMODE,
    output logic             dsp_CEAB,
    output logic             dsp_CEP,
    output logic             dsp_RSTP,
    input  logic [47:0]      dsp_P
);

    localparam int unsigned OP_W  = 18;
    localparam int unsigned P_W   = 48;
    localparam int unsigned PIPE  = 3;
    localparam logic [7:0]  OPMODE_FIRST = 8'h01;  // X=M, Z=0
    localparam logic [7:0]  OPMODE_ACC   = 8'h09;  // X=M, Z=P
    localparam logic [7:0]  OPMODE_IDLE  = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issue_cnt;
    logic [LEN_W-1:0] retire_cnt;
    logic [PIPE-1:0]  pipe_v;
    logic [PIPE-1:0]  pipe_last;
    logic             first_q;
    logic [P_W-1:0]   res_data_q;
    logic             issue;
    logic             issue_last;
    logic             accept;

    assign issue      = in_valid & in_ready;
    assign issue_last = issue & (issue_cnt == len_q - LEN_W'(1));
    assign accept     = (state == IDLE) & start & (len != '0) & ~RST;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && (len != '0)) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                in_ready = (issue_cnt < len_q);
                if (issue_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last pair is being written into P; it is readable next cycle.
                if (pipe_v[1] && pipe_last[1]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (RST) begin
            in_ready  = 1'b0;
            busy      = 1'b0;
            res_valid = 1'b0;
        end
    end

    // Counters, issue tracking pipeline and result holding register
    always_ff @(posedge CLK) begin
        if (RST) begin
            len_q      <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
            pipe_v     <= '0;
            pipe_last  <= '0;
            first_q    <= 1'b0;
            res_data_q <= '0;
        end else begin
            if (accept) begin
                len_q      <= len;
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (pipe_v[PIPE-1]) begin
                    retire_cnt <= retire_cnt + LEN_W'(1);
                end
            end
            pipe_v    <= {pipe_v[PIPE-2:0], issue};
            pipe_last <= {pipe_last[PIPE-2:0], issue_last};
            first_q   <= issue & (issue_cnt == '0);
            if (pipe_v[PIPE-1] && pipe_last[PIPE-1]) begin
                res_data_q <= dsp_P;
            end
        end
    end

    // P is a slice register and CEP stays low in DONE, so it is stable while presented.
    always_comb begin
        res_data = res_data_q;
        if (state == DONE) begin
            res_data = dsp_P;
        end
        if (RST) begin
            res_data = '0;
        end
    end

    // Slice control: operands on issue, OPMODE one cycle later, CEP two cycles later
    always_comb begin
        dsp_A      = issue ? in_a : OP_W'(0);
        dsp_B      = issue ? in_b : OP_W'(0);
        dsp_CEAB   = issue;
        dsp_OPMODE = OPMODE_IDLE;
        if (pipe_v[0] && !RST) begin
            dsp_OPMODE = first_q ? OPMODE_FIRST : OPMODE_ACC;
        end
        dsp_CEP  = pipe_v[1] & ~RST;
        dsp_RSTP = RST;
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP slice (A1/B1, M, OPMODE, P registers)
// and a result scoreboard fed by the stimulus and drained by an output monitor.
module tb_dsp_mac_sequencer;

    localparam int unsigned LEN_W = 8;

    logic             CLK;
    logic             RST;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a;
    logic [17:0]      in_b;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
    logic [17:0]      dsp_A;
    logic [17:0]      dsp_B;
    logic [7:0]       dsp_OPMODE;
    logic             dsp_CEAB;
    logic             dsp_CEP;
    logic             dsp_RSTP;
    logic [47:0]      dsp_P;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_CEAB(dsp_CEAB),
        .dsp_CEP(dsp_CEP), .dsp_RSTP(dsp_RSTP), .dsp_P(dsp_P)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural slice: A1REG=B1REG=MREG=PREG=OPMODEREG=1
    logic signed [17:0] a1_q = '0;
    logic signed [17:0] b1_q = '0;
    logic signed [35:0] prod;
    logic [47:0]        m_q = '0;
    logic [47:0]        p_q = '0;
    logic [7:0]         opm_q = '0;
    assign prod  = a1_q * b1_q;
    assign dsp_P = p_q;
    always @(posedge CLK) begin
        if (dsp_CEAB) begin
            a1_q <= dsp_A;
            b1_q <= dsp_B;
        end
        m_q   <= {{12{prod[35]}}, prod};
        opm_q <= dsp_OPMODE;
        if (dsp_RSTP)
            p_q <= '0;
        else if (dsp_CEP)
            p_q <= ((opm_q[3:2] == 2'b10) ? p_q : 48'd0) + ((opm_q[1:0] == 2'b01) ? m_q : 48'd0);
    end

    int passed = 0;
    int total  = 0;
    logic [47:0] exp_q[$];
    int          opm_cyc[$];
    logic [7:0]  opm_val[$];
    int          cep_cyc[$];
    int          issue_cyc[$];
    int          res_cyc = -1;
    logic [17:0] pa[3];
    logic [17:0] pb[3];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Output monitor: logs slice control activity and scores every delivered result
    always @(negedge CLK) begin
        if (dsp_OPMODE != 8'h00) begin
            opm_cyc.push_back(cyc);
            opm_val.push_back(dsp_OPMODE);
        end
        if (dsp_CEP) cep_cyc.push_back(cyc);
        if (in_valid && in_ready) issue_cyc.push_back(cyc);
        if (res_valid && res_ready && !RST) begin
            res_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_result", 64'(res_data), 64'hdead_0000_0000);
            else check("result", 64'(res_data), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        opm_cyc.delete();
        opm_val.delete();
        cep_cyc.delete();
        issue_cyc.delete();
        res_cyc = -1;
    endtask

    task automatic start_op(input int n);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send_pairs(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            in_a     = pa[i];
            in_b     = pb[i];
            in_valid = 1'b1;
            while (k < 40) begin
                @(negedge CLK);
                if (in_ready) break;
                k++;
            end
            if (k == 40) check("issue_timeout", 64'(k), 64'(0));
            tick();
            in_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_idle(output int at);
        int k = 0;
        at = -1;
        while (k < 60) begin
            @(negedge CLK);
            if (!busy) break;
            k++;
        end
        if (k == 60) check("idle_timeout", 64'(k), 64'(0));
        at = cyc;
    endtask

    initial begin
        int t;
        int idle_at;
        RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_rstp", 64'(dsp_RSTP), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_ctrl", 64'({dsp_OPMODE, dsp_CEAB, dsp_CEP}), 64'(0));
        check("rst_dsp_ab", 64'({dsp_A, dsp_B}), 64'(0));
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rstp_release", 64'(dsp_RSTP), 64'(0));
        tick();

        // Single pair 3*4
        clear_logs();
        pa[0] = 18'd3; pb[0] = 18'd4;
        exp_q.push_back(48'd12);
        start_op(1);
        send_pairs(1, 0);
        wait_idle(idle_at);
        t = (issue_cyc.size() > 0) ? issue_cyc[0] : -100;
        check("len1_result_cycle", 64'(res_cyc), 64'(t + 3));
        check("len1_idle_cycle", 64'(idle_at), 64'(t + 4));
        tick();

        // Three pairs back to back: 2 + 12 + 30
        clear_logs();
        pa[0] = 18'd1; pb[0] = 18'd2; pa[1] = 18'd3; pb[1] = 18'd4; pa[2] = 18'd5; pb[2] = 18'd6;
        exp_q.push_back(48'd44);
        start_op(3);
        send_pairs(3, 0);
        wait_idle(idle_at);
        t = (issue_cyc.size() > 0) ? issue_cyc[0] : -100;
        check("b2b_issues", 64'(issue_cyc.size()), 64'(3));
        check("b2b_opm_count", 64'(opm_val.size()), 64'(3));
        check("b2b_cep_count", 64'(cep_cyc.size()), 64'(3));
        for (int i = 0; i < 3 && i < opm_val.size() && i < cep_cyc.size(); i++) begin
            check("b2b_opm_val", 64'(opm_val[i]), (i == 0) ? 64'h01 : 64'h09);
            check("b2b_opm_cyc", 64'(opm_cyc[i]), 64'(t + 1 + i));
            check("b2b_cep_cyc", 64'(cep_cyc[i]), 64'(t + 2 + i));
        end
        tick();

        // Same pairs with two idle cycles between them
        clear_logs();
        exp_q.push_back(48'd44);
        start_op(3);
        send_pairs(3, 2);
        wait_idle(idle_at);
        check("gap_cep_count", 64'(cep_cyc.size()), 64'(3));
        for (int i = 0; i < 3 && i < cep_cyc.size() && i < issue_cyc.size(); i++)
            check("gap_cep_cyc", 64'(cep_cyc[i]), 64'(issue_cyc[i] + 2));
        tick();

        // Result back-pressure: hold res_ready low for five DONE cycles while start is pulsed
        clear_logs();
        res_ready = 1'b0;
        exp_q.push_back(48'd44);
        start_op(3);
        send_pairs(3, 0);
        begin
            int k = 0;
            while (k < 30 && !res_valid) begin
                @(negedge CLK);
                k++;
            end
            check("bp_res_valid_seen", 64'(res_valid), 64'(1));
        end
        start = 1'b1;
        len   = LEN_W'(1);
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", 64'(res_valid), 64'(1));
            check("bp_res_data", 64'(res_data), 64'(44));
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_busy", 64'(busy), 64'(1));
            tick();
            @(negedge CLK);
        end
        tick();
        start = 1'b0;
        res_ready = 1'b1;
        wait_idle(idle_at);
        repeat (3) begin
            @(negedge CLK);
            check("bp_stays_idle", 64'({busy, in_ready, res_valid}), 64'(0));
        end
        tick();

        // Reset aborts a running operation; the following one is independent of it
        clear_logs();
        pa[0] = 18'd1; pb[0] = 18'd2;
        start_op(3);
        send_pairs(1, 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(0));
        tick();
        pa[0] = 18'd7; pb[0] = 18'd8;
        exp_q.push_back(48'd56);
        start_op(1);
        send_pairs(1, 0);
        wait_idle(idle_at);
        tick();

        // Zero length request is ignored
        clear_logs();
        start_op(0);
        repeat (4) begin
            @(negedge CLK);
            check("len0_quiet", 64'({busy, in_ready, res_valid}), 64'(0));
        end

        check("pending_results", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
